dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, data-memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, data-memory word width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have ports p0_req / p1_req, input, 1, memory-stage access request from pipeline 0 / 1.
REQ-006 The block SHALL have ports p0_maddr / p1_maddr, input, ADDR_W, request address.
REQ-007 The block SHALL have ports p0_wdata / p1_wdata, input, DATA_W, store data.
REQ-008 The block SHALL have ports p0_write_mem / p1_write_mem, input, 1, 1 = store, 0 = load.
REQ-009 The block SHALL have ports p0_rdata / p1_rdata, output, DATA_W, registered load result per pipeline.
REQ-010 The block SHALL have ports p0_ack / p1_ack, output, 1, one-cycle pulse: that pipeline's access completed, rdata valid.
REQ-011 The block SHALL have ports mem_maddr, mem_wdata, mem_write_mem, output, ADDR_W/DATA_W/1, shared single-port data memory.
REQ-012 The block SHALL have port mem_rdata, input, DATA_W, memory read data, valid the cycle after mem_maddr is presented.
REQ-013 The block SHALL have port stall, output, 1, freeze request to the hazard unit (both pipelines hold one cycle).
REQ-014 The block SHALL have port conflict_cnt, output, 16, count of stall cycles.

Function
REQ-015 The FSM SHALL have states IDLE and SECOND; the issue slot in IDLE is combinational from inputs.
REQ-016 IDLE, exactly one req high: that request SHALL drive mem_* this cycle, stall=0, state stays IDLE.
REQ-017 IDLE, both req high: p0 (program-older) SHALL drive mem_*, p1 address/wdata/write SHALL be captured into a buffer, stall=1, next state SECOND, conflict_cnt increments.
REQ-018 SECOND: mem_* SHALL be driven from the buffer, stall=0, p0/p1 inputs SHALL NOT be issued (they are the held repeat), next state IDLE.
REQ-019 IDLE, no req: mem_write_mem SHALL be 0, mem_maddr/mem_wdata SHALL hold last driven value.
REQ-020 pN_ack SHALL pulse exactly one cycle after pN's access is issued, for loads and stores.
REQ-021 pN_rdata SHALL load mem_rdata on the cycle pN_ack is high for a load, and hold otherwise; stores SHALL NOT alter pN_rdata.
REQ-022 Latency: uncontended access = 1 cycle to ack; contended p1 = 2 cycles.
REQ-023 conflict_cnt SHALL saturate at 0xFFFF.
REQ-024 Ordering: for contended same-address pairs, final memory state SHALL equal p0 then p1 in sequence.

Reset
REQ-025 rst high SHALL asynchronously force state IDLE, buffer invalid, stall=0, p0_ack=p1_ack=0, p0_rdata=p1_rdata=0, conflict_cnt=0, mem_maddr=0, mem_wdata=0.
REQ-026 mem_write_mem SHALL be 0 combinationally while rst is high, including reset asserted in SECOND (buffered store discarded).
REQ-027 First access after rst deassertion SHALL be arbitrated from IDLE with no residual ack.

Configuration
REQ-028 Macro DM_ARB_FWD_EN, when defined, SHALL resolve same-address same-cycle pairs without stall: p0 store + p1 load -> issue p0 store, p1_rdata=p0_wdata and both acks next cycle; both stores -> issue only p1 store, both acks next cycle; both loads -> single read, both rdata loaded next cycle.
REQ-029 Without DM_ARB_FWD_EN, every dual request SHALL take the REQ-017/018 two-cycle sequence; conflict_cnt SHALL count only cycles where stall was asserted in either build.

Verification
REQ-030 p0 load 0x010 alone, mem[0x010]=0xBEEF -> cycle+1 p0_ack=1, p0_rdata=0xBEEF, stall never high.
REQ-031 p0 store 0x020=0x1234 and p1 load 0x030 same cycle -> stall=1 one cycle, p0_ack at +1, p1_ack at +2, conflict_cnt=1.
REQ-032 p0 store 0x040=0xAAAA, p1 load 0x040 same cycle: FWD_EN -> no stall, p1_rdata=0xAAAA at +1; no macro -> stall, p1_rdata=0xAAAA at +2.
REQ-033 p0 store 0x050=0x1111, p1 store 0x050=0x2222 same cycle -> mem[0x050]=0x2222 in both builds.
REQ-034 rst asserted during SECOND with buffered p1 store to 0x060 -> mem[0x060] unchanged, all outputs zero, IDLE on release.
REQ-035 Force 0x10000 contended cycles -> conflict_cnt reads 0xFFFF, no wrap.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-pipeline arbiter for one shared single-port data memory.
//
// Each cycle in IDLE the issue slot is chosen combinationally from the two
// memory-stage requests. When both pipelines request, p0 (program-older) goes
// first. p1 is captured into a one-entry buffer, and stall is raised so both
// pipelines hold for one cycle. In SECOND the buffered p1 access is issued,
// and the held repeat on the p0/p1 inputs is ignored.
//
// Optional feature (macro DM_ARB_FWD_EN): same-address, same-cycle pairs are
// resolved without a stall.
//   - p0 store + p1 load: p0's store data is forwarded to p1.
//   - Two stores: only p1's store is issued, since it would overwrite p0's.
//   - Two loads: a single read serves both pipelines.
//
// Ports
//   clk, rst                    : clock, asynchronous active-high reset
//   pN_req/maddr/wdata/write_mem: memory-stage request from pipeline N
//   pN_rdata, pN_ack            : load result and one-cycle completion pulse
//   mem_maddr/wdata/write_mem   : shared memory command
//   mem_rdata                   : memory read data, valid the cycle after the address
//   stall                       : freeze request to the hazard unit
//   conflict_cnt                : saturating count of stall cycles
//
// Handshake: a request is accepted in the cycle its issue slot is granted.
// It is never backpressured except through stall. pN_ack is high exactly
// one cycle after the issue, and pN_rdata is valid while pN_ack is high.
module dm_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_maddr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_write_mem,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_maddr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_write_mem,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p0_ack,
  output logic              p1_ack,
  output logic [ADDR_W-1:0] mem_maddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write_mem,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] buf_addr_q, last_addr_q, iss_addr;
  logic [DATA_W-1:0] buf_wdata_q, last_wdata_q, iss_wdata;
  logic              buf_write_q, buf_valid_q, iss_write;
  logic              stall_c, capture;
  logic              ack0_d, ack1_d, ld0_d, ld1_d, fwd1_d;
  logic              p0_ld_q, p1_ld_q, p1_fwd_q;
  logic [DATA_W-1:0] fwd_data_q, p0_rdata_q, p1_rdata_q, p1_src;
  logic [15:0]       conflict_q;
  logic              both;
  logic              fwd_st_ld, fwd_st_st, fwd_ld_ld;

  assign both = p0_req && p1_req;

`ifdef DM_ARB_FWD_EN
  logic same_addr;
  assign same_addr = (p0_maddr == p1_maddr);
  assign fwd_st_ld = both && same_addr && p0_write_mem && !p1_write_mem;
  assign fwd_st_st = both && same_addr && p0_write_mem && p1_write_mem;
  assign fwd_ld_ld = both && same_addr && !p0_write_mem && !p1_write_mem;
`else
  assign fwd_st_ld = 1'b0;
  assign fwd_st_st = 1'b0;
  assign fwd_ld_ld = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    iss_addr  = last_addr_q;   // address/data hold when nothing issues
    iss_wdata = last_wdata_q;
    iss_write = 1'b0;
    stall_c   = 1'b0;
    capture   = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    ld0_d     = 1'b0;
    ld1_d     = 1'b0;
    fwd1_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fwd_st_st) begin
          // p1's store would overwrite p0's, so p0's store never needs to reach memory
          iss_addr  = p1_maddr;
          iss_wdata = p1_wdata;
          iss_write = 1'b1;
          ack0_d    = 1'b1;
          ack1_d    = 1'b1;
        end else if (fwd_st_ld || fwd_ld_ld) begin
          iss_addr  = p0_maddr;
          iss_wdata = p0_wdata;
          iss_write = p0_write_mem;
          ack0_d    = 1'b1;
          ack1_d    = 1'b1;
          ld0_d     = fwd_ld_ld;
          ld1_d     = 1'b1;
          fwd1_d    = fwd_st_ld;
        end else if (p0_req) begin
          iss_addr  = p0_maddr;
          iss_wdata = p0_wdata;
          iss_write = p0_write_mem;
          ack0_d    = 1'b1;
          ld0_d     = !p0_write_mem;
          if (p1_req) begin
            capture = 1'b1;
            stall_c = 1'b1;
            state_d = SECOND;
          end
        end else if (p1_req) begin
          iss_addr  = p1_maddr;
          iss_wdata = p1_wdata;
          iss_write = p1_write_mem;
          ack1_d    = 1'b1;
          ld1_d     = !p1_write_mem;
        end
      end
      SECOND: begin
        if (buf_valid_q) begin
          iss_addr  = buf_addr_q;
          iss_wdata = buf_wdata_q;
          iss_write = buf_write_q;
          ack1_d    = 1'b1;
          ld1_d     = !buf_write_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= '0;
      buf_wdata_q  <= '0;
      buf_write_q  <= 1'b0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      p0_ld_q      <= 1'b0;
      p1_ld_q      <= 1'b0;
      p1_fwd_q     <= 1'b0;
      fwd_data_q   <= '0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      conflict_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_addr_q  <= iss_addr;
      last_wdata_q <= iss_wdata;
      if (capture) begin
        buf_addr_q  <= p1_maddr;
        buf_wdata_q <= p1_wdata;
        buf_write_q <= p1_write_mem;
        buf_valid_q <= 1'b1;
      end else if (state_q == SECOND) begin
        buf_valid_q <= 1'b0;
      end
      p0_ack     <= ack0_d;
      p1_ack     <= ack1_d;
      p0_ld_q    <= ld0_d;
      p1_ld_q    <= ld1_d;
      p1_fwd_q   <= fwd1_d;
      if (fwd1_d) fwd_data_q <= p0_wdata;
      p0_rdata_q <= p0_rdata;
      p1_rdata_q <= p1_rdata;
      if (stall_c && (conflict_q != 16'hFFFF)) conflict_q <= conflict_q + 16'd1;
    end
  end

  // mem_rdata only arrives in the ack cycle, so the load result is passed
  // through during ack and held in the register from then on.
  assign p1_src   = p1_fwd_q ? fwd_data_q : mem_rdata;
  assign p0_rdata = (p0_ack && p0_ld_q) ? mem_rdata : p0_rdata_q;
  assign p1_rdata = (p1_ack && p1_ld_q) ? p1_src : p1_rdata_q;

  // Issue is combinational from the inputs, so reset must also gate the
  // outputs. This discards a buffered store if reset hits in SECOND.
  assign mem_maddr     = rst ? '0 : iss_addr;
  assign mem_wdata     = rst ? '0 : iss_wdata;
  assign mem_write_mem = iss_write && !rst;
  assign stall         = stall_c && !rst;
  assign conflict_cnt  = conflict_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter. It includes a behavioural synchronous memory,
// a driver task for paired requests, and per-pipeline expected-ack queues
// that a negedge monitor checks.
module tb_dm_arbiter;

`ifdef DM_ARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p1_req, p0_write_mem, p1_write_mem;
  logic [8:0]  p0_maddr, p1_maddr;
  logic [15:0] p0_wdata, p1_wdata;
  logic [15:0] p0_rdata, p1_rdata;
  logic        p0_ack, p1_ack;
  logic [8:0]  mem_maddr;
  logic [15:0] mem_wdata;
  logic        mem_write_mem;
  logic [15:0] mem_rdata;
  logic        stall;
  logic [15:0] conflict_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // {expected ack cycle, expected rdata during ack}
  logic [47:0] exp0_q[$];
  logic [47:0] exp1_q[$];

  // memory model with a preload port
  logic [15:0] mem [0:511];
  logic        pre_we = 1'b0;
  logic [8:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  dm_arbiter #(.ADDR_W(9), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_maddr(p0_maddr), .p0_wdata(p0_wdata), .p0_write_mem(p0_write_mem),
    .p1_req(p1_req), .p1_maddr(p1_maddr), .p1_wdata(p1_wdata), .p1_write_mem(p1_write_mem),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata), .p0_ack(p0_ack), .p1_ack(p1_ack),
    .mem_maddr(mem_maddr), .mem_wdata(mem_wdata), .mem_write_mem(mem_write_mem),
    .mem_rdata(mem_rdata), .stall(stall), .conflict_cnt(conflict_cnt)
  );

  // clock / cycle counter / memory
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_write_mem) mem[mem_maddr] <= mem_wdata;
    mem_rdata <= mem[mem_maddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // monitor: pop and compare on every ack, flag missing/unexpected acks
  always @(negedge clk) begin
    if (!rst) begin
      if (p0_ack) begin
        if (exp0_q.size() == 0) chk("p0_ack_unexpected", 32'd1, 32'd0);
        else begin
          logic [47:0] e;
          e = exp0_q.pop_front();
          chk("p0_ack_cycle", cyc, e[47:16]);
          chk("p0_rdata", {16'd0, p0_rdata}, {16'd0, e[15:0]});
        end
      end else if (exp0_q.size() > 0 && exp0_q[0][47:16] < cyc) begin
        chk("p0_ack_missing", 32'd0, 32'd1);
        void'(exp0_q.pop_front());
      end
      if (p1_ack) begin
        if (exp1_q.size() == 0) chk("p1_ack_unexpected", 32'd1, 32'd0);
        else begin
          logic [47:0] e;
          e = exp1_q.pop_front();
          chk("p1_ack_cycle", cyc, e[47:16]);
          chk("p1_rdata", {16'd0, p1_rdata}, {16'd0, e[15:0]});
        end
      end else if (exp1_q.size() > 0 && exp1_q[0][47:16] < cyc) begin
        chk("p1_ack_missing", 32'd0, 32'd1);
        void'(exp1_q.pop_front());
      end
    end
  end

  task automatic poke(input logic [8:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic clear_inputs();
    p0_req = 1'b0; p0_maddr = '0; p0_wdata = '0; p0_write_mem = 1'b0;
    p1_req = 1'b0; p1_maddr = '0; p1_wdata = '0; p1_write_mem = 1'b0;
  endtask

  // One request pair. e0/e1 are the rdata values expected during each ack.
  // A stalled pair is held one extra cycle, as the hazard unit would do.
  task automatic access(input logic r0, input logic [8:0] a0, input logic [15:0] d0, input logic w0,
                        input logic r1, input logic [8:0] a1, input logic [15:0] d1, input logic w1,
                        input logic exp_stall, input int lat1,
                        input logic [15:0] e0, input logic [15:0] e1, input string tag);
    int c;
    @(posedge clk); #1;
    p0_req = r0; p0_maddr = a0; p0_wdata = d0; p0_write_mem = w0;
    p1_req = r1; p1_maddr = a1; p1_wdata = d1; p1_write_mem = w1;
    #1;
    chk({tag, "_stall"}, {31'd0, stall}, {31'd0, exp_stall});
    c = cyc;
    if (r0) exp0_q.push_back({c + 1, e0});
    if (r1) exp1_q.push_back({c + lat1, e1});
    if (exp_stall) begin
      @(posedge clk); #2;
      chk({tag, "_stall_second"}, {31'd0, stall}, 32'd0);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    // requests during reset must not reach memory
    p0_req = 1'b1; p0_maddr = 9'h005; p0_wdata = 16'hDEAD; p0_write_mem = 1'b1;
    #1;
    chk("rst_mem_write", {31'd0, mem_write_mem}, 32'd0);
    chk("rst_mem_maddr", {23'd0, mem_maddr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_acks", {30'd0, p0_ack, p1_ack}, 32'd0);
    chk("rst_rdata", {p0_rdata, p1_rdata}, 32'd0);
    chk("rst_conflict", {16'd0, conflict_cnt}, 32'd0);
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;

    poke(9'h010, 16'hBEEF);
    poke(9'h030, 16'h5A5A);
    poke(9'h060, 16'h6666);

    // uncontended load from p0, then from p1
    access(1, 9'h010, 16'h0, 0, 0, 9'h0, 16'h0, 0, 0, 1, 16'hBEEF, 16'h0, "p0_load");
    access(0, 9'h0, 16'h0, 0, 1, 9'h010, 16'h0, 0, 0, 1, 16'h0, 16'hBEEF, "p1_load");

    // contended store/load to different addresses
    access(1, 9'h020, 16'h1234, 1, 1, 9'h030, 16'h0, 0, 1, 2, 16'hBEEF, 16'h5A5A, "st_ld");
    chk("cnt_after_st_ld", {16'd0, conflict_cnt}, 32'd1);
    chk("mem_020", {16'd0, mem[9'h020]}, 32'h1234);

    // same-address store then load
    access(1, 9'h040, 16'hAAAA, 1, 1, 9'h040, 16'h0, 0, !FWD, FWD ? 1 : 2,
           16'hBEEF, 16'hAAAA, "same_st_ld");
    chk("cnt_after_same_st_ld", {16'd0, conflict_cnt}, FWD ? 32'd1 : 32'd2);
    chk("mem_040", {16'd0, mem[9'h040]}, 32'hAAAA);

    // same-address store pair: p1 wins
    access(1, 9'h050, 16'h1111, 1, 1, 9'h050, 16'h2222, 1, !FWD, FWD ? 1 : 2,
           16'hBEEF, 16'hAAAA, "same_st_st");
    chk("mem_050", {16'd0, mem[9'h050]}, 32'h2222);
    chk("cnt_after_same_st_st", {16'd0, conflict_cnt}, FWD ? 32'd1 : 32'd3);

    // idle: no write, address/data hold last driven values
    @(posedge clk); #2;
    chk("idle_write", {31'd0, mem_write_mem}, 32'd0);
    chk("idle_maddr_hold", {23'd0, mem_maddr}, 32'h050);
    chk("idle_wdata_hold", {16'd0, mem_wdata}, 32'h2222);

    // contended loads to different addresses
    access(1, 9'h030, 16'h0, 0, 1, 9'h010, 16'h0, 0, 1, 2, 16'h5A5A, 16'hBEEF, "ld_ld");
    chk("cnt_after_ld_ld", {16'd0, conflict_cnt}, FWD ? 32'd2 : 32'd4);

    // reset while the p1 store sits in the buffer
    @(posedge clk); #1;
    p0_req = 1'b1; p0_maddr = 9'h061; p0_wdata = 16'h0101; p0_write_mem = 1'b1;
    p1_req = 1'b1; p1_maddr = 9'h060; p1_wdata = 16'h7777; p1_write_mem = 1'b1;
    #1;
    chk("rst2nd_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst2nd_mem_write", {31'd0, mem_write_mem}, 32'd0);
    chk("rst2nd_maddr", {23'd0, mem_maddr}, 32'd0);
    chk("rst2nd_stall_low", {31'd0, stall}, 32'd0);
    chk("rst2nd_acks", {30'd0, p0_ack, p1_ack}, 32'd0);
    chk("rst2nd_rdata", {p0_rdata, p1_rdata}, 32'd0);
    chk("rst2nd_conflict", {16'd0, conflict_cnt}, 32'd0);
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_acks", {30'd0, p0_ack, p1_ack}, 32'd0);
    chk("mem_060_kept", {16'd0, mem[9'h060]}, 32'h6666);
    chk("mem_061_p0", {16'd0, mem[9'h061]}, 32'h0101);

    // first access after reset
    access(1, 9'h060, 16'h0, 0, 0, 9'h0, 16'h0, 0, 0, 1, 16'h6666, 16'h0, "after_rst");

    // saturation: preset the counter near the top, then keep contending
    @(posedge clk); #1;
    force dut.conflict_q = 16'hFFFD;
    #1;
    release dut.conflict_q;
    access(1, 9'h010, 16'h0, 0, 1, 9'h030, 16'h0, 0, 1, 2, 16'hBEEF, 16'h5A5A, "sat1");
    chk("cnt_sat1", {16'd0, conflict_cnt}, 32'hFFFE);
    access(1, 9'h010, 16'h0, 0, 1, 9'h030, 16'h0, 0, 1, 2, 16'hBEEF, 16'h5A5A, "sat2");
    chk("cnt_sat2", {16'd0, conflict_cnt}, 32'hFFFF);
    access(1, 9'h010, 16'h0, 0, 1, 9'h030, 16'h0, 0, 1, 2, 16'hBEEF, 16'h5A5A, "sat3");
    chk("cnt_sat3", {16'd0, conflict_cnt}, 32'hFFFF);

    repeat (4) @(posedge clk);
    #1;
    chk("exp0_drained", exp0_q.size(), 32'd0);
    chk("exp1_drained", exp1_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
